axil_master_cmd: RTL

- Single-outstanding AXI4-Lite master (initiator) for the register block's slave port.
- Converts a simple command stream (read/write, addr, data) into AW/W/B or AR/R transactions and returns one response per command.
- Used by host-side control logic, and as a reusable bus driver in benches, to program host_data registers (0x40+) and read statistics registers (0x00+).

---
 rtl/axil_pkg.sv | 27 ++
 rtl/axil_master_cmd.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared AXI4-Lite response codes, master FSM state encoding
//               and the data word returned on a watchdog timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/axil_master_cmd.sv
`default_nettype none
// ============================================================================
// Module      : axil_master_cmd
// Description : Single-outstanding AXI4-Lite master. Turns a command stream
//               (read/write, addr, data) into AW/W/B or AR/R transactions and
//               returns exactly one response per command. Every output is a
//               flop; the combinational block only computes next values.
//               Optional watchdog: define AXIL_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master_cmd
   import axil_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              aclk,
   input  logic              areset,
   // command stream
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   // response stream
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_resp,
   // AXI4-Lite master port
   output logic              m_axil_awvalid,
   output logic [ADDR_W-1:0] m_axil_awaddr,
   input  logic              m_axil_awready,
   output logic              m_axil_wvalid,
   output logic [DATA_W-1:0] m_axil_wdata,
   input  logic              m_axil_wready,
   input  logic              m_axil_bvalid,
   input  logic [1:0]        m_axil_bresp,
   output logic              m_axil_bready,
   output logic              m_axil_arvalid,
   output logic [ADDR_W-1:0] m_axil_araddr,
   input  logic              m_axil_arready,
   input  logic              m_axil_rvalid,
   input  logic [DATA_W-1:0] m_axil_rdata,
   input  logic [1:0]        m_axil_rresp,
   output logic              m_axil_rready
);

   // A watchdog shorter than two cycles could fire before any slave answers.
   if (TIMEOUT_CYC < 2) begin : g_timeout_cyc_chk
      $error("TIMEOUT_CYC must be at least 2");
   end

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_cmd_ready_nxt;
   logic                w_rsp_valid_nxt;
   logic                w_rsp_write_nxt;
   logic [DATA_W-1:0]   w_rsp_rdata_nxt;
   logic [1:0]          w_rsp_resp_nxt;
   logic                w_awvalid_nxt;
   logic [ADDR_W-1:0]   w_awaddr_nxt;
   logic                w_wvalid_nxt;
   logic [DATA_W-1:0]   w_wdata_nxt;
   logic                w_bready_nxt;
   logic                w_arvalid_nxt;
   logic [ADDR_W-1:0]   w_araddr_nxt;
   logic                w_rready_nxt;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int                c_wd_w   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT_CYC - 1);
   localparam logic [c_wd_w-1:0] c_wd_one = c_wd_w'(1);

   logic [c_wd_w-1:0] r_wd_cnt;
   logic              w_busy;
   logic              w_timeout;

   assign w_busy    = (r_state == ST_WR)      || (r_state == ST_WR_RESP) ||
                      (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);
   // Fires on the TIMEOUT_CYC-th cycle spent waiting on the bus.
   assign w_timeout = w_busy && (r_wd_cnt == c_wd_max);

   // Watchdog: counts bus-wait cycles, cleared whenever the FSM is not waiting.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_wd_cnt <= '0;
      end else if (!w_busy) begin
         r_wd_cnt <= '0;
      end else begin
         r_wd_cnt <= r_wd_cnt + c_wd_one;
      end
   end
`endif

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      w_state_nxt     = r_state;
      w_cmd_ready_nxt = cmd_ready;
      w_rsp_valid_nxt = rsp_valid;
      w_rsp_write_nxt = rsp_write;
      w_rsp_rdata_nxt = rsp_rdata;
      w_rsp_resp_nxt  = rsp_resp;
      w_awvalid_nxt   = m_axil_awvalid;
      w_awaddr_nxt    = m_axil_awaddr;
      w_wvalid_nxt    = m_axil_wvalid;
      w_wdata_nxt     = m_axil_wdata;
      w_bready_nxt    = m_axil_bready;
      w_arvalid_nxt   = m_axil_arvalid;
      w_araddr_nxt    = m_axil_araddr;
      w_rready_nxt    = m_axil_rready;

      case (r_state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               w_cmd_ready_nxt = 1'b0;
               if (cmd_write) begin
                  w_awaddr_nxt  = cmd_addr;
                  w_wdata_nxt   = cmd_wdata;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_state_nxt   = ST_WR;
               end else begin
                  w_araddr_nxt  = cmd_addr;
                  w_arvalid_nxt = 1'b1;
                  w_state_nxt   = ST_RD_ADDR;
               end
            end
         end
         ST_WR: begin
            // AW and W retire independently; each valid drops after its own handshake.
            w_awvalid_nxt = m_axil_awvalid && !m_axil_awready;
            w_wvalid_nxt  = m_axil_wvalid  && !m_axil_wready;
            if (!w_awvalid_nxt && !w_wvalid_nxt) begin
               w_bready_nxt = 1'b1;
               w_state_nxt  = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (m_axil_bvalid) begin
               w_bready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_write_nxt = 1'b1;
               w_rsp_rdata_nxt = '0;
               w_rsp_resp_nxt  = m_axil_bresp;
               w_state_nxt     = ST_RSP;
            end
         end
         ST_RD_ADDR: begin
            if (m_axil_arready) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (m_axil_rvalid) begin
               w_rready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_write_nxt = 1'b0;
               w_rsp_rdata_nxt = m_axil_rdata;
               w_rsp_resp_nxt  = m_axil_rresp;
               w_state_nxt     = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_cmd_ready_nxt = 1'b1;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_cmd_ready_nxt = 1'b1;
            w_rsp_valid_nxt = 1'b0;
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_state_nxt     = ST_IDLE;
         end
      endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Bus recovery: abandon the transfer and report SLVERR to the host.
      if (w_timeout) begin
         w_awvalid_nxt   = 1'b0;
         w_wvalid_nxt    = 1'b0;
         w_bready_nxt    = 1'b0;
         w_arvalid_nxt   = 1'b0;
         w_rready_nxt    = 1'b0;
         w_rsp_valid_nxt = 1'b1;
         w_rsp_write_nxt = (r_state == ST_WR) || (r_state == ST_WR_RESP);
         w_rsp_rdata_nxt = DATA_W'(TIMEOUT_DATA);
         w_rsp_resp_nxt  = RESP_SLVERR;
         w_state_nxt     = ST_RSP;
      end
`endif
   end

   // State and output registers; reset returns every output to idle at once.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state        <= ST_IDLE;
         cmd_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_write      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_resp       <= RESP_OKAY;
         m_axil_awvalid <= 1'b0;
         m_axil_awaddr  <= '0;
         m_axil_wvalid  <= 1'b0;
         m_axil_wdata   <= '0;
         m_axil_bready  <= 1'b0;
         m_axil_arvalid <= 1'b0;
         m_axil_araddr  <= '0;
         m_axil_rready  <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         cmd_ready      <= w_cmd_ready_nxt;
         rsp_valid      <= w_rsp_valid_nxt;
         rsp_write      <= w_rsp_write_nxt;
         rsp_rdata      <= w_rsp_rdata_nxt;
         rsp_resp       <= w_rsp_resp_nxt;
         m_axil_awvalid <= w_awvalid_nxt;
         m_axil_awaddr  <= w_awaddr_nxt;
         m_axil_wvalid  <= w_wvalid_nxt;
         m_axil_wdata   <= w_wdata_nxt;
         m_axil_bready  <= w_bready_nxt;
         m_axil_arvalid <= w_arvalid_nxt;
         m_axil_araddr  <= w_araddr_nxt;
         m_axil_rready  <= w_rready_nxt;
      end
   end

endmodule
`default_nettype wire
